// File: rtl/vending_slot_controller.sv
// rtl/vending_slot_controller.sv - per-slot stock/price vending controller with purchase handshake
// Requests are evaluated one at a time; a sale commits stock and revenue on the EVAL->RESP edge.
module vending_slot_controller #(
   parameter int NUM_SLOTS = 4,
   parameter int TAG_W     = 2,
   parameter int CNT_W     = 3,
   parameter int PRICE_W   = 3,
   parameter int MONEY_W   = 4,
   parameter int REV_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [TAG_W-1:0]     req_tag,
   input  logic [CNT_W-1:0]     req_count,
   input  logic [MONEY_W-1:0]   req_money,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic                 rsp_ok,
   output logic [MONEY_W-1:0]   rsp_change,
   output logic [1:0]           rsp_reason,
   input  logic                 cfg_we,
   input  logic [TAG_W-1:0]     cfg_tag,
   input  logic [CNT_W-1:0]     cfg_count,
   input  logic [PRICE_W-1:0]   cfg_price,
   output logic [NUM_SLOTS-1:0] slot_empty,
   output logic [REV_W-1:0]     revenue
);

   localparam int COST_W = CNT_W + PRICE_W;
   localparam int CMP_W  = (MONEY_W > COST_W) ? MONEY_W : COST_W;

   typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

   state_t state, state_nx;

   logic [CNT_W-1:0]   stock [NUM_SLOTS];
   logic [PRICE_W-1:0] price [NUM_SLOTS];

   logic [TAG_W-1:0]   tag_q;
   logic [CNT_W-1:0]   count_q;
   logic [MONEY_W-1:0] money_q;
   logic [REV_W-1:0]   revenue_q;
   logic               rsp_ok_q;
   logic [MONEY_W-1:0] rsp_change_q;
   logic [1:0]         rsp_reason_q;

   logic               accept;
   logic               cfg_apply;
   logic               cfg_tag_ok;
   logic               tag_ok;
   logic [CNT_W-1:0]   sel_stock;
   logic [PRICE_W-1:0] sel_price;
   logic [COST_W-1:0]  cost;
   logic [CMP_W-1:0]   money_x;
   logic [CMP_W-1:0]   cost_x;
   logic [CMP_W-1:0]   change_x;
   logic [1:0]         reason;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Config writes win over requests, and only land while idle.
   always_comb begin
      state_nx  = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      accept    = 1'b0;
      cfg_apply = 1'b0;
      case (state)
         IDLE: begin
            req_ready = !cfg_we;
            cfg_apply = cfg_we;
            accept    = req_valid && !cfg_we;
            if (accept) begin
               state_nx = EVAL;
            end
         end
         EVAL: begin
            state_nx = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Money is widened so a cost larger than MONEY_W can hold still compares correctly.
   always_comb begin
      tag_ok     = 32'(tag_q) < 32'(NUM_SLOTS);
      cfg_tag_ok = 32'(cfg_tag) < 32'(NUM_SLOTS);
      sel_stock  = '0;
      sel_price  = '0;
      if (tag_ok) begin
         sel_stock = stock[tag_q];
         sel_price = price[tag_q];
      end
      cost     = COST_W'(count_q) * COST_W'(sel_price);
      money_x  = CMP_W'(money_q);
      cost_x   = CMP_W'(cost);
      change_x = money_x - cost_x;
      if ((count_q == '0) || !tag_ok) begin
         reason = 2'd3;
      end else if (count_q > sel_stock) begin
         reason = 2'd1;
      end else if (money_x < cost_x) begin
         reason = 2'd2;
      end else begin
         reason = 2'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            stock[i] <= '0;
            price[i] <= '0;
         end
         tag_q        <= '0;
         count_q      <= '0;
         money_q      <= '0;
         revenue_q    <= '0;
         rsp_ok_q     <= 1'b0;
         rsp_change_q <= '0;
         rsp_reason_q <= 2'd0;
      end else begin
         if (cfg_apply && cfg_tag_ok) begin
            stock[cfg_tag] <= cfg_count;
            price[cfg_tag] <= cfg_price;
         end
         if (accept) begin
            tag_q   <= req_tag;
            count_q <= req_count;
            money_q <= req_money;
         end
         if (state == EVAL) begin
            rsp_reason_q <= reason;
            if (reason == 2'd0) begin
               rsp_ok_q       <= 1'b1;
               rsp_change_q   <= change_x[MONEY_W-1:0];
               stock[tag_q]   <= sel_stock - count_q;
               revenue_q      <= revenue_q + REV_W'(cost);
            end else begin
               rsp_ok_q     <= 1'b0;
               rsp_change_q <= money_q;
            end
         end
      end
   end

   always_comb begin
      slot_empty = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         slot_empty[i] = (stock[i] == '0);
      end
   end

   assign rsp_ok     = rsp_ok_q;
   assign rsp_change = rsp_change_q;
   assign rsp_reason = rsp_reason_q;
   assign revenue    = revenue_q;

endmodule

// File: tb/tb_vending_slot_controller.sv
// tb/tb_vending_slot_controller.sv - scoreboard bench for vending_slot_controller
// Three slots so that tag 3 exercises the out-of-range request path.
module tb_vending_slot_controller;

   localparam int NS = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic [1:0]    req_tag;
   logic [2:0]    req_count;
   logic [3:0]    req_money;
   logic          rsp_valid;
   logic          rsp_ready;
   logic          rsp_ok;
   logic [3:0]    rsp_change;
   logic [1:0]    rsp_reason;
   logic          cfg_we;
   logic [1:0]    cfg_tag;
   logic [2:0]    cfg_count;
   logic [2:0]    cfg_price;
   logic [NS-1:0] slot_empty;
   logic [15:0]   revenue;

   vending_slot_controller #(
      .NUM_SLOTS(NS), .TAG_W(2), .CNT_W(3), .PRICE_W(3), .MONEY_W(4), .REV_W(16)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
      .req_count(req_count), .req_money(req_money),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ok(rsp_ok),
      .rsp_change(rsp_change), .rsp_reason(rsp_reason),
      .cfg_we(cfg_we), .cfg_tag(cfg_tag), .cfg_count(cfg_count), .cfg_price(cfg_price),
      .slot_empty(slot_empty), .revenue(revenue)
   );

   always #5 clk = ~clk;

   typedef struct {
      int ok;
      int change;
      int reason;
      int rev;
      int empty;
   } exp_t;

   exp_t sb[$];
   int   m_stk[NS];
   int   m_prc[NS];
   int   m_rev;
   int   total = 0;
   int   bad   = 0;
   bit   hold  = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int empty_mask();
      int m = 0;
      for (int i = 0; i < NS; i++) if (m_stk[i] == 0) m |= (1 << i);
      return m;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NS; i++) begin
         m_stk[i] = 0;
         m_prc[i] = 0;
      end
      m_rev = 0;
   endtask

   task automatic model_cfg(input int t, input int c, input int p);
      if (t < NS) begin
         m_stk[t] = c;
         m_prc[t] = p;
      end
   endtask

   // Sale rules applied directly: validity, stock, funds, then commit.
   function automatic exp_t model_req(input int t, input int c, input int money);
      exp_t e;
      int cost;
      e.ok = 0;
      e.change = money;
      if (c == 0 || t >= NS) e.reason = 3;
      else if (c > m_stk[t]) e.reason = 1;
      else begin
         cost = c * m_prc[t];
         if (money < cost) e.reason = 2;
         else begin
            e.reason = 0;
            e.ok = 1;
            e.change = money - cost;
            m_stk[t] -= c;
            m_rev = (m_rev + cost) % 65536;
         end
      end
      e.rev = m_rev;
      e.empty = empty_mask();
      return e;
   endfunction

   initial begin
      rsp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_rsp", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("rsp_ok", int'(rsp_ok), e.ok);
               chk("rsp_change", int'(rsp_change), e.change);
               chk("rsp_reason", int'(rsp_reason), e.reason);
               chk("revenue", int'(revenue), e.rev);
               chk("slot_empty", int'(slot_empty), e.empty);
            end
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic do_cfg(input int t, input int c, input int p);
      wait_idle();
      cfg_we = 1'b1;
      cfg_tag = 2'(t);
      cfg_count = 3'(c);
      cfg_price = 3'(p);
      @(posedge clk);
      model_cfg(t, c, p);
      #1 cfg_we = 1'b0;
   endtask

   task automatic do_req(input int t, input int c, input int money, input bit with_cfg = 1'b0,
                         input int ct = 0, input int cc = 0, input int cp = 0);
      int n = 0;
      if (with_cfg) wait_idle();
      else @(negedge clk);
      req_valid = 1'b1;
      req_tag = 2'(t);
      req_count = 3'(c);
      req_money = 4'(money);
      if (with_cfg) begin
         cfg_we = 1'b1;
         cfg_tag = 2'(ct);
         cfg_count = 3'(cc);
         cfg_price = 3'(cp);
         #1 chk("cfg_blocks_req", int'(req_ready), 0);
         @(posedge clk);
         model_cfg(ct, cc, cp);
         #1 cfg_we = 1'b0;
         @(negedge clk);
      end
      #1;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!req_ready) begin
         chk("req_accept_timeout", 0, 1);
         req_valid = 1'b0;
         return;
      end
      sb.push_back(model_req(t, c, money));
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_rsp_valid();
      int n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!rsp_valid) chk("rsp_valid_timeout", 0, 1);
   endtask

   initial begin
      exp_t e;
      rst_n = 1'b0;
      req_valid = 1'b0;
      req_tag = '0;
      req_count = '0;
      req_money = '0;
      cfg_we = 1'b0;
      cfg_tag = '0;
      cfg_count = '0;
      cfg_price = '0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset_req_ready", int'(req_ready), 1);
      chk("reset_rsp_valid", int'(rsp_valid), 0);
      chk("reset_slot_empty", int'(slot_empty), 7);
      chk("reset_revenue", int'(revenue), 0);
      chk("reset_rsp_fields", int'({rsp_ok, rsp_change, rsp_reason}), 0);

      do_cfg(1, 5, 3);
      do_req(1, 2, 9);
      do_req(1, 4, 15);
      do_cfg(2, 7, 7);
      do_req(2, 3, 15);
      do_req(0, 0, 5);
      do_req(3, 1, 6);

      wait_idle();
      hold = 1'b1;
      do_req(1, 1, 4);
      wait_rsp_valid();
      e = sb[0];
      for (int i = 0; i < 5; i++) begin
         chk("hold_rsp_valid", int'(rsp_valid), 1);
         chk("hold_req_ready", int'(req_ready), 0);
         chk("hold_rsp_change", int'(rsp_change), e.change);
         chk("hold_rsp_ok", int'(rsp_ok), e.ok);
         if (i == 1) begin
            cfg_we = 1'b1;
            cfg_tag = 2'd1;
            cfg_count = 3'd7;
            cfg_price = 3'd1;
         end else begin
            cfg_we = 1'b0;
         end
         @(negedge clk);
      end
      cfg_we = 1'b0;
      hold = 1'b0;

      do_req(0, 1, 5, 1'b1, 0, 2, 2);
      do_req(1, 2, 6);
      wait_idle();
      chk("slot1_empty_after_sellout", int'(slot_empty[1]), 1);

      for (int it = 0; it < 120; it++) begin
         if ($urandom_range(0, 4) == 0)
            do_cfg($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7));
         else
            do_req($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 15));
      end

      do_cfg(2, 4, 1);
      hold = 1'b1;
      do_req(2, 1, 7);
      wait_rsp_valid();
      rst_n = 1'b0;
      #1;
      chk("midrst_rsp_valid", int'(rsp_valid), 0);
      chk("midrst_rsp_fields", int'({rsp_ok, rsp_change, rsp_reason}), 0);
      chk("midrst_revenue", int'(revenue), 0);
      chk("midrst_slot_empty", int'(slot_empty), 7);
      chk("midrst_req_ready", int'(req_ready), 1);
      sb.delete();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      hold = 1'b0;
      do_req(2, 1, 7);
      do_cfg(0, 3, 2);
      do_req(0, 3, 15);
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
